// File: rtl/uart_tx_ctrl.sv
// UART TX frame sequencer: START, DATA, optional PARITY, STOP.
// Drives the TX mux select, the serializer load/shift strobes and busy.
//
// Ports:
//   CLK        in   TX bit clock, one clock per UART bit
//   RST        in   asynchronous reset, active-low
//   DATA_VALID in   frame request, sampled in IDLE and STOP only
//   PAR_EN     in   parity enable, latched when a frame is accepted
//   data_load  out  serializer load strobe (frame accepted this cycle)
//   ser_en     out  serializer shift enable, high in every DATA cycle
//   ser_idx    out  index of the data bit on the line, LSB first
//   mux_sel    out  00 start, 01 stop/idle, 10 data, 11 parity
//   busy       out  frame in progress
module uart_tx_ctrl #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                          CLK,
    input  logic                          RST,
    input  logic                          DATA_VALID,
    input  logic                          PAR_EN,
    output logic                          data_load,
    output logic                          ser_en,
    output logic [$clog2(DATA_WIDTH)-1:0] ser_idx,
    output logic [1:0]                    mux_sel,
    output logic                          busy
);

    localparam int CW = $clog2(DATA_WIDTH);
    localparam logic [CW-1:0] LAST = CW'(DATA_WIDTH - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   bit_cnt_q, bit_cnt_d;
    logic            par_en_q, par_en_d;

    // Gating with RST keeps a request from being accepted while in reset.
    assign data_load = DATA_VALID & RST &
                       ((state_q == IDLE) | (state_q == STOP));

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q   <= IDLE;
            bit_cnt_q <= '0;
            par_en_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            par_en_q  <= par_en_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        par_en_d  = par_en_q;
        if (data_load) begin
            par_en_d = PAR_EN;
        end
        unique case (state_q)
            IDLE: begin
                if (DATA_VALID) begin
                    state_d = START;
                end
            end
            START: begin
                state_d   = DATA;
                bit_cnt_d = '0;
            end
            DATA: begin
                if (bit_cnt_q == LAST) begin
                    state_d = par_en_q ? PARITY : STOP;
                end else begin
                    bit_cnt_d = bit_cnt_q + 1'b1;
                end
            end
            PARITY: begin
                state_d = STOP;
            end
            STOP: begin
                state_d = DATA_VALID ? START : IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Moore decode; the async state reset forces line-high at once.
    always_comb begin
        mux_sel = 2'b01;
        busy    = 1'b0;
        ser_en  = 1'b0;
        unique case (state_q)
            IDLE: begin
                mux_sel = 2'b01;
            end
            START: begin
                mux_sel = 2'b00;
                busy    = 1'b1;
            end
            DATA: begin
                mux_sel = 2'b10;
                busy    = 1'b1;
                ser_en  = 1'b1;
            end
            PARITY: begin
                mux_sel = 2'b11;
                busy    = 1'b1;
            end
            STOP: begin
                mux_sel = 2'b01;
                busy    = 1'b1;
            end
            default: begin
                mux_sel = 2'b01;
            end
        endcase
    end

    // bit_cnt holds outside DATA, so the index is simply the counter.
    assign ser_idx = bit_cnt_q;

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Testbench for uart_tx_ctrl: directed frames with a queued scoreboard.
// Stimulus pushes per-cycle expectations; a negedge monitor checks them.
module tb_uart_tx_ctrl;

    logic       CLK;
    logic       RST;
    logic       DATA_VALID;
    logic       PAR_EN;
    logic       data_load;
    logic       ser_en;
    logic [2:0] ser_idx;
    logic [1:0] mux_sel;
    logic       busy;

    int total = 0;
    int bad   = 0;
    int cyc_n = 0;

    typedef struct {
        logic       dl;
        logic [1:0] mux;
        logic       bsy;
        logic       sen;
        logic [2:0] idx;
        int         id;
    } exp_t;

    exp_t sb[$];

    uart_tx_ctrl #(.DATA_WIDTH(8)) dut (
        .CLK        (CLK),
        .RST        (RST),
        .DATA_VALID (DATA_VALID),
        .PAR_EN     (PAR_EN),
        .data_load  (data_load),
        .ser_en     (ser_en),
        .ser_idx    (ser_idx),
        .mux_sel    (mux_sel),
        .busy       (busy)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string nm, input int act, input int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, req);
        end
    endtask

    // Monitor: compares the DUT against the oldest queued expectation.
    always @(negedge CLK) begin
        if (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            chk($sformatf("c%0d data_load", e.id), int'(data_load), int'(e.dl));
            chk($sformatf("c%0d mux_sel", e.id), int'(mux_sel), int'(e.mux));
            chk($sformatf("c%0d busy", e.id), int'(busy), int'(e.bsy));
            chk($sformatf("c%0d ser_en", e.id), int'(ser_en), int'(e.sen));
            if (e.sen) begin
                chk($sformatf("c%0d ser_idx", e.id), int'(ser_idx), int'(e.idx));
            end
        end
    end

    task automatic cyc(input logic dv, input logic pe, input logic dl,
                       input logic [1:0] mux, input logic bsy,
                       input logic sen, input logic [2:0] idx);
        exp_t e;
        @(posedge CLK);
        #1;
        DATA_VALID = dv;
        PAR_EN     = pe;
        e.dl  = dl;
        e.mux = mux;
        e.bsy = bsy;
        e.sen = sen;
        e.idx = idx;
        e.id  = cyc_n;
        cyc_n++;
        sb.push_back(e);
    endtask

    task automatic data8(input logic dv, input logic pe);
        for (int i = 0; i < 8; i++) begin
            cyc(dv, pe, 1'b0, 2'b10, 1'b1, 1'b1, 3'(i));
        end
    endtask

    task automatic idle1();
        cyc(1'b0, 1'b0, 1'b0, 2'b01, 1'b0, 1'b0, 3'd0);
    endtask

    task automatic async_chk(input string tag);
        chk({tag, " mux_sel"}, int'(mux_sel), 1);
        chk({tag, " busy"}, int'(busy), 0);
        chk({tag, " ser_en"}, int'(ser_en), 0);
        chk({tag, " data_load"}, int'(data_load), 0);
    endtask

    initial begin
        RST        = 1'b0;
        DATA_VALID = 1'b1;
        PAR_EN     = 1'b1;
        #2;
        async_chk("reset");
        chk("reset ser_idx", int'(ser_idx), 0);
        @(negedge CLK);
        DATA_VALID = 1'b0;
        RST        = 1'b1;

        // Single frame with parity.
        idle1();
        cyc(1'b1, 1'b1, 1'b1, 2'b01, 1'b0, 1'b0, 3'd0);
        cyc(1'b0, 1'b0, 1'b0, 2'b00, 1'b1, 1'b0, 3'd0);
        data8(1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b0, 2'b11, 1'b1, 1'b0, 3'd0);
        cyc(1'b0, 1'b0, 1'b0, 2'b01, 1'b1, 1'b0, 3'd0);
        idle1();

        // Single frame without parity.
        cyc(1'b1, 1'b0, 1'b1, 2'b01, 1'b0, 1'b0, 3'd0);
        cyc(1'b0, 1'b1, 1'b0, 2'b00, 1'b1, 1'b0, 3'd0);
        data8(1'b0, 1'b1);
        cyc(1'b0, 1'b0, 1'b0, 2'b01, 1'b1, 1'b0, 3'd0);
        idle1();
        idle1();

        // Back-to-back frames with DATA_VALID held high.
        cyc(1'b1, 1'b1, 1'b1, 2'b01, 1'b0, 1'b0, 3'd0);
        for (int f = 0; f < 2; f++) begin
            cyc(1'b1, 1'b1, 1'b0, 2'b00, 1'b1, 1'b0, 3'd0);
            data8(1'b1, 1'b1);
            cyc(1'b1, 1'b1, 1'b0, 2'b11, 1'b1, 1'b0, 3'd0);
            if (f == 0) begin
                cyc(1'b1, 1'b1, 1'b1, 2'b01, 1'b1, 1'b0, 3'd0);
            end else begin
                cyc(1'b0, 1'b1, 1'b0, 2'b01, 1'b1, 1'b0, 3'd0);
            end
        end
        idle1();

        // PAR_EN toggled mid-frame, stray DATA_VALID during DATA.
        cyc(1'b1, 1'b1, 1'b1, 2'b01, 1'b0, 1'b0, 3'd0);
        cyc(1'b0, 1'b0, 1'b0, 2'b00, 1'b1, 1'b0, 3'd0);
        for (int i = 0; i < 8; i++) begin
            cyc(1'(i == 3), 1'(i % 2), 1'b0, 2'b10, 1'b1, 1'b1, 3'(i));
        end
        cyc(1'b0, 1'b0, 1'b0, 2'b11, 1'b1, 1'b0, 3'd0);
        cyc(1'b0, 1'b0, 1'b0, 2'b01, 1'b1, 1'b0, 3'd0);
        idle1();
        idle1();

        // Reset asserted during DATA.
        cyc(1'b1, 1'b1, 1'b1, 2'b01, 1'b0, 1'b0, 3'd0);
        cyc(1'b0, 1'b1, 1'b0, 2'b00, 1'b1, 1'b0, 3'd0);
        cyc(1'b0, 1'b1, 1'b0, 2'b10, 1'b1, 1'b1, 3'd0);
        cyc(1'b0, 1'b1, 1'b0, 2'b10, 1'b1, 1'b1, 3'd1);
        @(posedge CLK);
        #2;
        DATA_VALID = 1'b1;
        RST        = 1'b0;
        #1;
        async_chk("midrst");
        @(posedge CLK);
        #1;
        async_chk("midrst hold");
        @(negedge CLK);
        DATA_VALID = 1'b0;
        RST        = 1'b1;
        idle1();
        idle1();
        idle1();
        cyc(1'b1, 1'b0, 1'b1, 2'b01, 1'b0, 1'b0, 3'd0);
        cyc(1'b0, 1'b0, 1'b0, 2'b00, 1'b1, 1'b0, 3'd0);
        data8(1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b0, 2'b01, 1'b1, 1'b0, 3'd0);
        idle1();

        for (int k = 0; k < 5 && sb.size() > 0; k++) begin
            @(negedge CLK);
            #1;
        end
        @(negedge CLK);
        #1;
        if (sb.size() != 0) begin
            total++;
            bad++;
            $display("FAIL drain: %0d left, expected 0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
